// File: rtl/transmission_machine.sv
// Byte-stream transmission controller: one session per sink request, latching
// each ready source byte onto a registered output and flagging mid-session underrun.
module transmission_machine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       req,
  input  logic       drdy,
  input  logic [7:0] data,
  output logic [7:0] y,
  output logic       ack,
  output logic       idl,
  output logic       exc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_EXC  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   load;

  // NOTE: the reset is synchronous, so it is tested inside the clocked branch;
  // state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      y     <= 8'h00;
    end else begin
      state <= state_nxt;
      if (load) y <= data;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (!ena) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (req) state_nxt = ST_WAIT;
        ST_WAIT, ST_EXC: begin
          if (!req) begin
            state_nxt = ST_IDLE;
          end else if (drdy) begin
            state_nxt = ST_SEND;
            load      = 1'b1;
          end
        end
        ST_SEND: begin
          if (!req) begin
            state_nxt = ST_IDLE;
          end else if (drdy) begin
            load = 1'b1;
          end else begin
            state_nxt = ST_EXC;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Moore decode: flags depend on the state register alone.
  always_comb begin
    idl = (state == ST_IDLE);
    ack = (state == ST_SEND);
    exc = (state == ST_EXC);
  end

endmodule

// File: tb/tb_transmission_machine.sv
// Directed-vector bench for transmission_machine; inputs change #1 after the
// rising edge and outputs are checked at that same point, one edge after stimulus.
module tb_transmission_machine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       req;
  logic       drdy;
  logic [7:0] data;
  logic [7:0] y;
  logic       ack;
  logic       idl;
  logic       exc;

  int vectors = 0;
  int miscompares = 0;

  transmission_machine dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .req  (req),
    .drdy (drdy),
    .data (data),
    .y    (y),
    .ack  (ack),
    .idl  (idl),
    .exc  (exc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected values are packed as {y, ack, idl, exc}.
  task automatic expect_out(input string name, input logic [7:0] ey,
                            input logic ea, input logic ei, input logic ee);
    vectors++;
    if ({y, ack, idl, exc} !== {ey, ea, ei, ee}) begin
      miscompares++;
      $display("FAIL %s: got y=%h ack=%b idl=%b exc=%b, want y=%h ack=%b idl=%b exc=%b",
               name, y, ack, idl, exc, ey, ea, ei, ee);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'($urandom);
    req   = 1'($urandom);
    drdy  = 1'($urandom);
    data  = 8'($urandom);
    step();
    ena  = 1'($urandom);
    req  = 1'($urandom);
    drdy = 1'($urandom);
    data = 8'($urandom);
    step();
    expect_out("reset_state", 8'h00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    ena   = 1'b0;
    req   = 1'b1;
    drdy  = 1'b1;
    step();
    expect_out("reset_release_ena0", 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("ena0_holds_idle", 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_basic();
    ena  = 1'b1;
    data = 8'hAA;
    req  = 1'b1;
    drdy = 1'b0;
    step();
    expect_out("basic_wait1", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("basic_wait2", 8'h00, 1'b0, 1'b0, 1'b0);
    drdy = 1'b1;
    step();
    expect_out("basic_send", 8'hAA, 1'b1, 1'b0, 1'b0);
    req  = 1'b0;
    drdy = 1'b0;
    step();
    expect_out("basic_req_fall", 8'hAA, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_streaming();
    req  = 1'b1;
    drdy = 1'b0;
    step();
    expect_out("stream_wait", 8'hAA, 1'b0, 1'b0, 1'b0);
    drdy = 1'b1;
    data = 8'h01;
    step();
    expect_out("stream_01", 8'h01, 1'b1, 1'b0, 1'b0);
    data = 8'h02;
    step();
    expect_out("stream_02", 8'h02, 1'b1, 1'b0, 1'b0);
    data = 8'h03;
    step();
    expect_out("stream_03", 8'h03, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_underrun();
    drdy = 1'b0;
    data = 8'hEE;
    step();
    expect_out("underrun_exc", 8'h03, 1'b0, 1'b0, 1'b1);
    step();
    expect_out("underrun_hold", 8'h03, 1'b0, 1'b0, 1'b1);
    drdy = 1'b1;
    data = 8'h55;
    step();
    expect_out("underrun_recover", 8'h55, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    data  = 8'h66;
    step();
    expect_out("reset_mid_send", 8'h00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    drdy  = 1'b0;
    step();
    expect_out("reset_mid_restart_wait", 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    req = 1'b0;
    step();
    expect_out("abort_in_wait", 8'h00, 1'b0, 1'b1, 1'b0);
    req  = 1'b1;
    drdy = 1'b1;
    data = 8'h77;
    step();
    expect_out("req_drdy_rise_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    data = 8'h88;
    step();
    expect_out("capture_after_wait", 8'h88, 1'b1, 1'b0, 1'b0);
    req  = 1'b0;
    data = 8'h99;
    step();
    expect_out("req_wins_in_send", 8'h88, 1'b0, 1'b1, 1'b0);
    req  = 1'b1;
    drdy = 1'b0;
    step();
    drdy = 1'b1;
    data = 8'hC3;
    step();
    expect_out("send_before_ena0", 8'hC3, 1'b1, 1'b0, 1'b0);
    ena  = 1'b0;
    data = 8'h3C;
    step();
    expect_out("ena0_in_send", 8'hC3, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_exc_abort();
    ena  = 1'b1;
    req  = 1'b1;
    drdy = 1'b0;
    step();
    drdy = 1'b1;
    data = 8'h11;
    step();
    expect_out("exc_path_send", 8'h11, 1'b1, 1'b0, 1'b0);
    drdy = 1'b0;
    step();
    expect_out("exc_path_exc", 8'h11, 1'b0, 1'b0, 1'b1);
    req  = 1'b0;
    drdy = 1'b1;
    data = 8'h22;
    step();
    expect_out("req_wins_in_exc", 8'h11, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_streaming();
    test_underrun();
    test_reset_mid();
    test_abort();
    test_exc_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
